fifo_mem: RTL and testbench
===========================

// Module: fifo_mem
// PURPOSE
//  Storage stage of the FIFO, directly downstream of the write-side register stage.
//  Takes the registered mem_wr_en/mem_wr_data and serves reads from the read side.
//  Returns mem_full/mem_wr_err, which the write stage registers back to fifo_full/fifo_wr_err.
//  Because that path adds one cycle of lag, the block also provides an early almost-full flag.
// PARAMETERS
//  DATA_W     8  width of one stored word
//  DEPTH      8  number of entries; must be a power of 2, >= 4
//  AF_MARGIN  2  mem_almost_full asserts when count >= DEPTH-AF_MARGIN
// PORTS
//  CLK              in   1           single clock, all logic on posedge
//  RST              in   1           synchronous reset, active-high
//  mem_wr_en        in   1           write request, from the write stage
//  mem_wr_data      in   DATA_W      write data
//  mem_rd_en        in   1           read request, from the read side
//  mem_rd_data      out  DATA_W      read data, registered
//  mem_rd_valid     out  1           mem_rd_data updated this cycle
//  mem_full         out  1           count == DEPTH
//  mem_almost_full  out  1           count >= DEPTH-AF_MARGIN
//  mem_empty        out  1           count == 0
//  mem_wr_err       out  1           one-cycle pulse: write attempted while full
//  mem_rd_err       out  1           one-cycle pulse: read attempted while empty
//  mem_count        out  ADDR_W+1    occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (sync, RST=1 at posedge):
//    - wr_ptr=0, rd_ptr=0, count=0, empty=1.
//    - full=0, almost_full=0, both err=0, rd_valid=0, rd_data=0.
//    - Storage array is not reset. Reset overrides any request in the same cycle.
//  - Write accepted iff mem_wr_en && !mem_full (registered state at that edge).
//    - Accepted: array[wr_ptr] <= data; wr_ptr <= wr_ptr+1.
//  - Write while full: data dropped, pointers unchanged, mem_wr_err=1 for the next cycle only.
//  - Read accepted iff mem_rd_en && !mem_empty.
//    - Accepted: mem_rd_data <= array[rd_ptr]; rd_ptr++; mem_rd_valid=1 next cycle.
//    - Latency is 1 cycle.
//  - Read while empty: mem_rd_err=1 next cycle, rd_valid=0, mem_rd_data holds its last value.
//  - mem_rd_data holds its value whenever no read is accepted.
//  - No write-to-read bypass: a word is readable one cycle after it is written.
//  - Simultaneous rd+wr:
//    - Each request is qualified on the current flags independently.
//    - Mid-range: both accepted, count unchanged.
//    - Full: read accepted, write rejected with mem_wr_err; count -> DEPTH-1.
//    - Empty: write accepted, read rejected with mem_rd_err; count -> 1.
//  - count_next = count + wr_acc - rd_acc.
//    - Flags are registered from count_next, so they are valid in the same cycle as mem_count.
//  - Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
// STRUCTURE
//  - fifo_param_pkg holds:
//    - DATA_W/DEPTH defaults and ADDR_W.
//    - typedefs word_t (logic [DATA_W-1:0]), ptr_t, cnt_t.
//  - fifo_if gains a FIFO_mem modport carrying the ports above.
//  - One sub-module, fifo_ptr_ctrl, owns pointers, count and flags/err generation.
//  - fifo_mem keeps the storage array and the read data register.
// TESTING (DATA_W=8, DEPTH=8, AF_MARGIN=2)
//  1. Hold RST 2 cycles with wr_en=rd_en=1.
//     -> empty=1, full=0, count=0, rd_valid=0, no err pulses.
//  2. Write 0xA0..0xA7 on consecutive cycles.
//     -> almost_full rises after the 6th write, full=1 and count=8 after the 8th.
//  3. At full, write 0xFF.
//     -> wr_err high exactly 1 cycle, count stays 8.
//     -> Then read 8 words: rd_data=A0..A7 in order, rd_valid each cycle, empty=1 after the last.
//  4. At empty, assert rd_en.
//     -> rd_err high 1 cycle, rd_valid=0, rd_data stays 0xA7.
//  5. Wrap: write 5, read 5, write 0xB0..0xB5, read 6.
//     -> B0..B5 in order, pointers wrapped, count returns to 0.
//  6. Simultaneous rd+wr at count=3.
//     -> count stays 3.
//     -> At full: read returns the head, write rejected with wr_err, count=7.
//     -> Assert RST mid-stream: next cycle count=0, empty=1.

Source files
------------

// File: rtl/fifo_mem_pkg.sv
// Shared defaults and word/pointer/count types for the FIFO storage stage.
package fifo_param_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W     = ADDR_W + 1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/fifo_mem_if.sv
// Storage-stage bus: write stage and read side on one side, fifo_mem on the other.
interface fifo_if #(
  parameter int unsigned DATA_W = fifo_param_pkg::DATA_W,
  parameter int unsigned DEPTH  = fifo_param_pkg::DEPTH
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_full;
  logic              mem_almost_full;
  logic              mem_empty;
  logic              mem_wr_err;
  logic              mem_rd_err;
  logic [ADDR_W:0]   mem_count;

  modport FIFO_mem (
    input  mem_wr_en, mem_wr_data, mem_rd_en,
    output mem_rd_data, mem_rd_valid, mem_full, mem_almost_full, mem_empty,
           mem_wr_err, mem_rd_err, mem_count
  );

  modport master (
    output mem_wr_en, mem_wr_data, mem_rd_en,
    input  mem_rd_data, mem_rd_valid, mem_full, mem_almost_full, mem_empty,
           mem_wr_err, mem_rd_err, mem_count
  );

endinterface

// File: rtl/fifo_mem_ptr_ctrl.sv
// Pointer, occupancy and flag/error generation for the FIFO storage stage.
module fifo_ptr_ctrl
  import fifo_param_pkg::*;
#(
  parameter  int unsigned DEPTH     = fifo_param_pkg::DEPTH,
  parameter  int unsigned AF_MARGIN = fifo_param_pkg::AF_MARGIN,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CW        = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_acc_c,
  output logic             rd_acc_c,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             wr_err,
  output logic             rd_err
);

  logic [CW-1:0] count_next;

  // Requests qualify on the registered flags independently of each other.
  always_comb begin
    wr_acc_c   = wr_en && !full;
    rd_acc_c   = rd_en && !empty;
    count_next = count + CW'(wr_acc_c) - CW'(rd_acc_c);
  end

  // Flags derive from count_next so they line up with count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      empty       <= 1'b1;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      almost_full <= (count_next >= CW'(DEPTH - AF_MARGIN));
      empty       <= (count_next == '0);
      wr_err      <= wr_en && full;
      rd_err      <= rd_en && empty;
    end
  end

endmodule

// File: rtl/fifo_mem.sv
// FIFO storage stage: word array plus registered read port, control in fifo_ptr_ctrl.
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W    = fifo_param_pkg::DATA_W,
  parameter int unsigned DEPTH     = fifo_param_pkg::DEPTH,
  parameter int unsigned AF_MARGIN = fifo_param_pkg::AF_MARGIN
) (
  input logic     CLK,
  input logic     RST,
  fifo_if.FIFO_mem bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc_c;
  logic              rd_acc_c;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_ptr_ctrl (
    .CLK         (CLK),
    .RST         (RST),
    .wr_en       (bus.mem_wr_en),
    .rd_en       (bus.mem_rd_en),
    .wr_acc_c    (wr_acc_c),
    .rd_acc_c    (rd_acc_c),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (bus.mem_count),
    .full        (bus.mem_full),
    .almost_full (bus.mem_almost_full),
    .empty       (bus.mem_empty),
    .wr_err      (bus.mem_wr_err),
    .rd_err      (bus.mem_rd_err)
  );

  // Array is deliberately left unreset; only accepted writes touch it.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc_c) store[wr_ptr] <= bus.mem_wr_data;
  end

  // Read data holds between accepted reads; no same-cycle write bypass.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.mem_rd_data  <= '0;
      bus.mem_rd_valid <= 1'b0;
    end else begin
      bus.mem_rd_valid <= rd_acc_c;
      if (rd_acc_c) bus.mem_rd_data <= store[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fifo_mem.sv
// Directed plus randomized bench for fifo_mem against a queue-based reference model.
module tb_fifo_mem;

  localparam int unsigned DW   = 8;
  localparam int unsigned DEP  = 8;
  localparam int unsigned AFM  = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  fifo_mem #(.DATA_W(DW), .DEPTH(DEP), .AF_MARGIN(AFM)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] e_rd_data = '0;
  logic          e_rd_valid = 1'b0;
  logic          e_wr_err   = 1'b0;
  logic          e_rd_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ":count"},    32'(bus.mem_count),       32'(sz));
    chk({tag, ":empty"},    32'(bus.mem_empty),       32'(sz == 0));
    chk({tag, ":full"},     32'(bus.mem_full),        32'(sz == DEP));
    chk({tag, ":afull"},    32'(bus.mem_almost_full), 32'(sz >= DEP - AFM));
    chk({tag, ":wr_err"},   32'(bus.mem_wr_err),      32'(e_wr_err));
    chk({tag, ":rd_err"},   32'(bus.mem_rd_err),      32'(e_rd_err));
    chk({tag, ":rd_valid"}, 32'(bus.mem_rd_valid),    32'(e_rd_valid));
    chk({tag, ":rd_data"},  32'(bus.mem_rd_data),     32'(e_rd_data));
  endtask

  // One clock: drive requests, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input bit rst, input bit wr,
                      input logic [DW-1:0] d, input bit rd);
    bit wr_ok, rd_ok;
    RST             = rst;
    bus.mem_wr_en   = wr;
    bus.mem_wr_data = d;
    bus.mem_rd_en   = rd;
    @(posedge CLK);
    #1;
    if (rst) begin
      q.delete();
      e_rd_data  = '0;
      e_rd_valid = 1'b0;
      e_wr_err   = 1'b0;
      e_rd_err   = 1'b0;
    end else begin
      wr_ok      = wr && (q.size() < DEP);
      rd_ok      = rd && (q.size() > 0);
      e_wr_err   = wr && !wr_ok;
      e_rd_err   = rd && !rd_ok;
      e_rd_valid = rd_ok;
      if (rd_ok) e_rd_data = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    check_all(tag);
  endtask

  initial begin
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_data = 8'h55;
    bus.mem_rd_en   = 1'b1;

    // Reset with both requests asserted.
    step("rst0", 1, 1, 8'h55, 1);
    step("rst1", 1, 1, 8'h66, 1);

    // Fill from empty.
    for (int i = 0; i < 8; i++) begin
      step("fill", 0, 1, DW'(8'hA0 + i), 0);
      if (i == 4) chk("af_low_after5", 32'(bus.mem_almost_full), 32'd0);
      if (i == 5) chk("af_high_after6", 32'(bus.mem_almost_full), 32'd1);
    end
    chk("full_after8", 32'(bus.mem_full), 32'd1);

    // Overflow attempt, then pulse must drop.
    step("ovf", 0, 1, 8'hFF, 0);
    chk("ovf_pulse", 32'(bus.mem_wr_err), 32'd1);
    step("ovf_idle", 0, 0, 8'h00, 0);
    chk("ovf_pulse_gone", 32'(bus.mem_wr_err), 32'd0);

    // Drain.
    for (int i = 0; i < 8; i++) begin
      step("drain", 0, 0, 8'h00, 1);
      chk("drain_data", 32'(bus.mem_rd_data), 32'(8'hA0 + i));
    end

    // Underflow attempt: data must hold A7.
    step("udf", 0, 0, 8'h00, 1);
    chk("udf_hold", 32'(bus.mem_rd_data), 32'hA7);
    step("udf_idle", 0, 0, 8'h00, 0);

    // Pointer wrap.
    for (int i = 0; i < 5; i++) step("wrap_w5", 0, 1, DW'($urandom), 0);
    for (int i = 0; i < 5; i++) step("wrap_r5", 0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) step("wrap_wb", 0, 1, DW'(8'hB0 + i), 0);
    for (int i = 0; i < 6; i++) begin
      step("wrap_rb", 0, 0, 8'h00, 1);
      chk("wrap_data", 32'(bus.mem_rd_data), 32'(8'hB0 + i));
    end
    chk("wrap_empty", 32'(bus.mem_count), 32'd0);

    // Simultaneous read and write mid-range, at full, then reset mid-stream.
    for (int i = 0; i < 3; i++) step("sim_pre", 0, 1, DW'(8'hC0 + i), 0);
    for (int i = 0; i < 4; i++) step("sim_mid", 0, 1, DW'(8'hD0 + i), 1);
    chk("sim_mid_count", 32'(bus.mem_count), 32'd3);
    for (int i = 0; i < 5; i++) step("sim_fill", 0, 1, DW'(8'hE0 + i), 0);
    step("sim_full", 0, 1, 8'h99, 1);
    chk("sim_full_count", 32'(bus.mem_count), 32'd7);
    chk("sim_full_werr", 32'(bus.mem_wr_err), 32'd1);
    step("sim_more", 0, 1, 8'h77, 1);
    step("sim_rst", 1, 1, 8'h88, 1);
    chk("sim_rst_empty", 32'(bus.mem_empty), 32'd1);

    // Random traffic with phase-dependent write/read bias and rare resets.
    for (int ph = 0; ph < 4; ph++) begin
      int wb, rb;
      wb = (ph % 2 == 0) ? 80 : 30;
      rb = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 100; i++) begin
        step("rand", ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < wb), DW'($urandom),
             ($urandom_range(0, 99) < rb));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
